// File: rtl/octal_digit_sequencer.sv
// octal_digit_sequencer: streams a signed word as a sign flag plus MSB-first octal digits over valid/ready
module octal_digit_sequencer #(
  parameter bit SKIP_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_digit,
  output logic        out_sign,
  output logic        out_first,
  output logic        out_last,
  output logic        busy
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_n;
  logic [31:0] mag, mag_n, in_mag;
  logic [32:0] in_ext, sh;
  logic [3:0]  idx, idx_n, start;
  logic [5:0]  shamt;
  logic        sign, sign_n, first, first_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      idx   <= '0;
      sign  <= 1'b0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      mag   <= mag_n;
      idx   <= idx_n;
      sign  <= sign_n;
      first <= first_n;
    end
  end
  always_comb begin
    state_n = state;
    mag_n   = mag;
    idx_n   = idx;
    sign_n  = sign;
    first_n = first;
    in_mag  = in_data[31] ? ~in_data + 32'd1 : in_data;
    in_ext  = {1'b0, in_mag};
    start   = 4'd10;
    for (int k = 10; k >= 0; k--)
      if (in_ext[3*(10-k) +: 3] != 3'd0) start = 4'(k);
    shamt   = 6'd30 - 6'(idx) * 6'd3;
    sh      = {1'b0, mag} >> shamt;
    if (state == IDLE) begin
      if (in_valid) begin
        state_n = EMIT;
        mag_n   = in_mag;
        sign_n  = !in_data[31];
        idx_n   = SKIP_LZ ? start : 4'd0;
        first_n = 1'b1;
      end
    end else if (idx > 4'd10) begin
      state_n = IDLE;
    end else if (out_ready) begin
      state_n = (idx == 4'd10) ? IDLE : EMIT;
      idx_n   = (idx == 4'd10) ? idx : idx + 4'd1;
      first_n = 1'b0;
    end
  end
  assign in_ready  = (state == IDLE);
  assign busy      = (state == EMIT);
  assign out_valid = (state == EMIT) && (idx <= 4'd10);
  assign out_digit = out_valid ? sh[2:0] : 3'd0;
  assign out_first = out_valid && first;
  assign out_last  = out_valid && (idx == 4'd10);
  assign out_sign  = sign;
endmodule

// File: tb/tb_octal_digit_sequencer.sv
// tb_octal_digit_sequencer: scoreboard bench for both SKIP_LZ settings against a base-8 reference model
module tb_octal_digit_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, out_sign, out_first, out_last, busy;
  logic [31:0] in_data [2];
  logic [2:0]  out_digit [2];
  logic [5:0]  q0 [$];
  logic [5:0]  q1 [$];
  logic [5:0]  prev [2];
  logic [5:0]  cur, e;
  logic [1:0]  stall, last_sign;
  logic        rand_rdy;
  int          nchecks = 0;
  int          nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    octal_digit_sequencer #(.SKIP_LZ(g == 0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_digit(out_digit[g]),
      .out_sign(out_sign[g]), .out_first(out_first[g]), .out_last(out_last[g]),
      .busy(busy[g])
    );
  end
  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", n, i, act, exp, $time);
    end
  endtask
  function automatic void model(int i, logic [31:0] w);
    logic s = !($signed(w) < 0);
    longint m = ($signed(w) < 0) ? -longint'($signed(w)) : longint'(w);
    int d [$];
    do begin
      d.push_front(int'(m % 8));
      m = m / 8;
    end while (m != 0);
    if (i == 1) while (d.size() < 11) d.push_front(0);
    foreach (d[k]) begin
      if (i == 0) q0.push_back({3'(d[k]), s, k == 0, k == d.size() - 1});
      else q1.push_back({3'(d[k]), s, k == 0, k == d.size() - 1});
    end
  endfunction
  task automatic send(int i, logic [31:0] w);
    int t = 0;
    in_data[i] = w;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready[i]) begin
      chk("accept_timeout", i, 0, 1);
      in_valid[i] = 1'b0;
    end else begin
      model(i, w);
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
      in_data[i] = $urandom;
      chk("latency", i, out_valid[i], 1);
    end
  endtask
  task automatic drain();
    int t = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && in_valid == 2'b00 && busy == 2'b00) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", 0, (q0.size() == 0 && q1.size() == 0 && busy == 2'b00), 1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    stall = 2'b00;
    last_sign = 2'b00;
  endtask
  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return $urandom_range(0, 600);
      2: return -$urandom_range(1, 600);
      3: return ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h7fff_ffff);
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 2'($urandom);
  end
  initial forever begin
    @(negedge clk);
    if (!rst) for (int i = 0; i < 2; i++) begin
      cur = {out_digit[i], out_sign[i], out_first[i], out_last[i]};
      chk("ready_vs_busy", i, in_ready[i], !busy[i]);
      if (stall[i]) chk("stall_hold", i, {out_valid[i], cur}, {1'b1, prev[i]});
      if (out_valid[i]) begin
        stall[i] = !out_ready[i];
        prev[i] = cur;
        if (out_ready[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) chk("unexpected_digit", i, cur, 0);
          else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("digit", i, cur, e);
            last_sign[i] = e[2];
          end
        end
      end else begin
        stall[i] = 1'b0;
        chk("idle_zero", i, {out_digit[i], out_first[i], out_last[i]}, 0);
        chk("idle_sign", i, out_sign[i], last_sign[i]);
      end
    end
  end
  initial begin
    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b00;
    in_data[0] = 0;
    in_data[1] = 0;
    rand_rdy = 1'b0;
    stall = 2'b00;
    last_sign = 2'b00;
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", i, in_ready[i], 1);
      chk("rst_outs", i, {out_valid[i], out_digit[i], out_sign[i], out_first[i], out_last[i], busy[i]}, 0);
    end
    out_ready = 2'b11;
    send(0, 83);
    send(0, -8);
    send(0, 0);
    send(0, 32'h8000_0000);
    send(1, 83);
    send(1, -1);
    drain();
    send(0, 83);
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    fork
      send(0, 5);
    join_none
    for (int c = 0; c < 3; c++) begin
      chk("bp_digit", 0, {out_valid[0], out_digit[0], out_first[0], out_last[0]}, {1'b1, 3'd2, 2'b00});
      chk("bp_in_ready", 0, in_ready[0], 0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    drain();
    send(0, 83);
    @(posedge clk);
    #1;
    do_reset();
    chk("midrst", 0, {out_valid[0], busy[0], in_ready[0], out_sign[0]}, 4'b0010);
    send(0, 7);
    chk("after_rst_digit", 0, {out_digit[0], out_first[0], out_last[0]}, {3'd7, 2'b11});
    drain();
    rand_rdy = 1'b1;
    fork
      for (int n = 0; n < 40; n++) send(0, rand_word());
      for (int n = 0; n < 40; n++) send(1, rand_word());
    join
    drain();
    rand_rdy = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/octal_digit_sequencer.md
Name: octal_digit_sequencer

Overview:
Streaming controller that turns a 32-bit signed word into a sign flag plus a sequence of octal digits, most significant first, over a valid/ready handshake. It owns the group index: it steps through the eleven 3-bit groups of the word's magnitude (group 0 = {1'b0, mag[31:30]}, group 10 = mag[2:0]). It optionally suppresses leading zeros. It sits between a word producer and a digit consumer such as a display or UART formatter.

Parameters:
SKIP_LZ, 1, 1 = suppress leading zero digits (a zero word still emits one '0'); 0 = always emit all 11 digits

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  producer presents in_data
in_ready  out  1  block can accept a word
in_data  in  32  signed two's-complement word
out_valid  out  1  out_digit/out_sign/out_first/out_last are valid
out_ready  in  1  consumer accepts the current digit
out_digit  out  3  current octal digit
out_sign  out  1  0 = negative, 1 = positive or zero; constant for the whole word
out_first  out  1  current digit is the first of the word
out_last  out  1  current digit is the last of the word (group 10)
busy  out  1  a word is captured and not yet fully emitted

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. in_ready=1 on the following cycle. out_valid=0, out_digit=0, out_sign=0, out_first=0, out_last=0, busy=0. Reset wins over every other event, including mid-emission; a partially emitted word is discarded.
- States: IDLE and EMIT.
- in_ready = (state==IDLE). This is combinational from state only, with no path from out_ready.
- IDLE, on in_valid && in_ready:
  - Capture sign = (in_data<0) ? 0 : 1.
  - Capture mag = (in_data<0) ? (~in_data+1) : in_data, held as 32-bit unsigned. For -2147483648, mag=32'h8000_0000; no overflow handling is needed.
  - Set idx = start index, then go to EMIT with first_flag=1.
  - Start index with SKIP_LZ=1: the lowest group index g in 0..10 whose group is nonzero. If mag==0, the start index is 10. This is a priority encode in the capture cycle.
  - Start index with SKIP_LZ=0: 0.
- Latency: out_valid=1 on the cycle immediately after acceptance.
- EMIT:
  - out_valid=1.
  - out_digit = group(mag, idx).
  - out_first = first_flag.
  - out_last = (idx==10).
  - busy=1.
- Handshake:
  - A digit transfers on out_valid && out_ready.
  - Without a transfer, all outputs hold stable, whatever the number of stall cycles.
  - On transfer with idx<10: idx increments by 1 and first_flag clears. Zeros after the first emitted digit are always emitted; SKIP_LZ affects only leading zeros.
  - On transfer with idx==10: go to IDLE. out_valid=0 and in_ready=1 on the next cycle. There is no bypass; a new word is accepted no earlier than one cycle after the last digit transfers.
- Output drive:
  - out_digit/out_first/out_last are driven 0 whenever out_valid=0.
  - out_sign holds its last captured value in IDLE, and is 0 after reset.
- Digit count per word: 11 - start index, in the range 1..11.
- idx is a 4-bit field; values 11..15 are unreachable. If ever reached, they are treated as IDLE recovery (state returns to IDLE, no digit emitted).
- in_data is ignored outside the acceptance cycle.

Test Plan:
- SKIP_LZ=1, in_data=83 (octal 123), out_ready=1 -> digits 1,2,3 on three consecutive cycles. out_sign=1 throughout. out_first only on '1', out_last only on '3'. in_ready returns 1 one cycle after '3'.
- SKIP_LZ=1, in_data=-8 -> out_sign=0, digits 1,0; out_last on '0'. Then in_data=0 -> a single digit 0 with out_first=out_last=1 and out_sign=1.
- SKIP_LZ=1, in_data=32'h8000_0000 (-2^31) -> out_sign=0, 11 digits: '2' followed by ten '0'. out_first on '2', out_last on the 11th digit.
- SKIP_LZ=0, in_data=83 -> 11 digits 0,0,0,0,0,0,0,0,1,2,3. out_first on the first '0', out_last on '3'.
- Backpressure: in_data=83 (SKIP_LZ=1), out_ready low for 3 cycles while '2' is presented -> out_digit=2, out_first=0, out_last=0 held stable for all 3 cycles. In parallel, in_valid=1 with in_data=5 during EMIT -> in_ready=0 and 5 is not captured until IDLE.
- Reset mid-word: assert rst after the first digit of 83 transfers -> next cycle out_valid=0, busy=0, in_ready=1, out_sign=0. A following word 7 emits the single digit 7 with out_first=out_last=1.
